// File: rtl/avl_vlb_burst_master_pkg.sv
// Shared types for the Avalon-MM burst master.
package avl_vlb_burst_master_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITE     = 2'd1,
        READ_REQ  = 2'd2,
        READ_DATA = 2'd3
    } state_t;

endpackage

// File: rtl/avl_vlb_burst_master.sv
// Avalon-MM burst master: one write or read burst in flight at a time, driven
// by a command port, a write-data stream sink and a read-data stream source.
module avl_vlb_burst_master
    import avl_vlb_burst_master_pkg::*;
#(
    parameter int unsigned DWIDTH = 8,
    parameter int unsigned AWIDTH = 8,
    parameter int unsigned BWIDTH = 8
) (
    input  logic              reset,
    input  logic              clk,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_rnw,
    input  logic [AWIDTH-1:0] cmd_address,
    input  logic [BWIDTH-1:0] cmd_length,
    input  logic [DWIDTH-1:0] wr_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    output logic [DWIDTH-1:0] rd_data,
    output logic              rd_valid,
    output logic [AWIDTH-1:0] avm_address,
    output logic [BWIDTH-1:0] avm_burstcount,
    output logic              avm_write,
    output logic [DWIDTH-1:0] avm_writedata,
    output logic              avm_read,
    input  logic [DWIDTH-1:0] avm_readdata,
    input  logic              avm_readdatavalid,
    input  logic              avm_waitrequest,
    output logic              busy,
    output logic              err
);

    localparam logic [BWIDTH-1:0] MAX_LEN = {1'b1, {(BWIDTH-1){1'b0}}};

    state_t state;
    state_t state_next;

    logic [BWIDTH-1:0] loaded;
    logic [BWIDTH-1:0] accepted;
    logic [BWIDTH-1:0] received;

    logic cmd_take;
    logic cmd_legal;
    logic load;
    logic wr_take;
    logic wr_accept;
    logic rd_beat;
    logic last_wr;
    logic last_rd;

    // Handshake decode; avm_burstcount doubles as the captured length.
    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign cmd_take  = cmd_valid & cmd_ready;
    assign cmd_legal = (cmd_length != '0) && (cmd_length <= MAX_LEN);
    assign load      = ~avm_write | ~avm_waitrequest;
    assign wr_ready  = (state == WRITE) & load & (loaded < avm_burstcount);
    assign wr_take   = wr_valid & wr_ready;
    assign wr_accept = (state == WRITE) & avm_write & ~avm_waitrequest;
    assign rd_beat   = (state == READ_DATA) & avm_readdatavalid;
    assign last_wr   = wr_accept && ((accepted + BWIDTH'(1)) == avm_burstcount);
    assign last_rd   = rd_beat && ((received + BWIDTH'(1)) == avm_burstcount);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (cmd_take && cmd_legal) begin
                    state_next = cmd_rnw ? READ_REQ : WRITE;
                end
            end
            WRITE: begin
                if (last_wr) begin
                    state_next = IDLE;
                end
            end
            READ_REQ: begin
                if (!avm_waitrequest) begin
                    state_next = READ_DATA;
                end
            end
            READ_DATA: begin
                if (last_rd) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Command capture, write output stage, read request and read return path.
    always_ff @(posedge clk) begin
        if (reset) begin
            avm_address    <= '0;
            avm_burstcount <= '0;
            avm_write      <= 1'b0;
            avm_writedata  <= '0;
            avm_read       <= 1'b0;
            rd_data        <= '0;
            rd_valid       <= 1'b0;
            err            <= 1'b0;
            loaded         <= '0;
            accepted       <= '0;
            received       <= '0;
        end else begin
            err      <= cmd_take & ~cmd_legal;
            rd_valid <= rd_beat;

            if (cmd_take) begin
                avm_address    <= cmd_address;
                avm_burstcount <= cmd_length;
                loaded         <= '0;
                accepted       <= '0;
                received       <= '0;
            end

            // One-deep stage: refill only when the slave has taken the held beat.
            if (wr_take) begin
                avm_writedata <= wr_data;
                avm_write     <= 1'b1;
                loaded        <= loaded + BWIDTH'(1);
            end else if (load) begin
                avm_write <= 1'b0;
            end

            if (wr_accept) begin
                accepted <= accepted + BWIDTH'(1);
            end

            if (cmd_take && cmd_legal && cmd_rnw) begin
                avm_read <= 1'b1;
            end else if ((state == READ_REQ) && !avm_waitrequest) begin
                avm_read <= 1'b0;
            end

            if (rd_beat) begin
                rd_data  <= avm_readdata;
                received <= received + BWIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_avl_vlb_burst_master.sv
// Bench for avl_vlb_burst_master: inline burst memory slave with random
// waitrequest and read latency 4, plus a read-data scoreboard.
module tb_avl_vlb_burst_master;

    localparam int unsigned DW = 16;
    localparam int unsigned AW = 8;
    localparam int unsigned BW = 8;

    logic          clk   = 1'b0;
    logic          reset = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_rnw = 1'b0;
    logic [AW-1:0] cmd_address = '0;
    logic [BW-1:0] cmd_length = '0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_valid = 1'b0;
    logic          wr_ready;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic [AW-1:0] avm_address;
    logic [BW-1:0] avm_burstcount;
    logic          avm_write;
    logic [DW-1:0] avm_writedata;
    logic          avm_read;
    logic [DW-1:0] avm_readdata = '0;
    logic          avm_readdatavalid = 1'b0;
    logic          avm_waitrequest = 1'b0;
    logic          busy;
    logic          err;

    always #5 clk = ~clk;

    avl_vlb_burst_master #(.DWIDTH(DW), .AWIDTH(AW), .BWIDTH(BW)) dut (
        .reset(reset), .clk(clk),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rnw(cmd_rnw),
        .cmd_address(cmd_address), .cmd_length(cmd_length),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid),
        .avm_address(avm_address), .avm_burstcount(avm_burstcount),
        .avm_write(avm_write), .avm_writedata(avm_writedata), .avm_read(avm_read),
        .avm_readdata(avm_readdata), .avm_readdatavalid(avm_readdatavalid),
        .avm_waitrequest(avm_waitrequest),
        .busy(busy), .err(err)
    );

    int tests = 0;
    int fails = 0;

    logic [DW-1:0] exp_q[$];
    int rd_cnt = 0;
    int err_cnt = 0;
    int viol = 0;
    int stab_bad = 0;
    int ready_bad = 0;
    logic watch_ready = 1'b0;
    logic [AW-1:0] exp_addr = '0;
    logic [BW-1:0] exp_len = '0;

    // Slave memory model state.
    logic [DW-1:0] mem [256];
    bit            p_rst = 1'b1;
    bit            p_wr = 1'b0;
    bit            p_rd = 1'b0;
    logic [DW-1:0] p_wdata = '0;
    logic [AW-1:0] p_addr = '0;
    logic [BW-1:0] p_len = '0;
    int            s_wbeat = 0;
    int            s_wr_total = 0;
    logic [AW-1:0] s_raddr = '0;
    int            s_rleft = 0;
    int            s_ridx = 0;
    int            s_rdelay = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Handshakes as seen by the DUT at the rising edge.
    always @(posedge clk) begin
        p_rst   = reset;
        p_wr    = avm_write && !avm_waitrequest;
        p_rd    = avm_read && !avm_waitrequest;
        p_wdata = avm_writedata;
        p_addr  = avm_address;
        p_len   = avm_burstcount;
    end

    // Slave response, applied away from the active edge.
    always @(negedge clk) begin
        if (p_rst) begin
            s_wbeat = 0;
        end else if (p_wr) begin
            mem[8'(p_addr + 8'(s_wbeat))] = p_wdata;
            s_wbeat++;
            s_wr_total++;
            if (s_wbeat == int'(p_len)) s_wbeat = 0;
        end
        if (!p_rst && p_rd) begin
            s_raddr  = p_addr;
            s_rleft  = int'(p_len);
            s_ridx   = 0;
            s_rdelay = 4;
        end
        if (s_rleft > 0 && s_rdelay > 1) begin
            s_rdelay--;
            avm_readdatavalid = 1'b0;
        end else if (s_rleft > 0) begin
            avm_readdatavalid = 1'b1;
            avm_readdata      = mem[8'(s_raddr + 8'(s_ridx))];
            s_ridx++;
            s_rleft--;
        end else begin
            avm_readdatavalid = 1'b0;
            avm_readdata      = '0;
        end
        avm_waitrequest = ($urandom_range(0, 99) < 30);
    end

    // Monitor: protocol watch and read-data scoreboard.
    always @(negedge clk) begin
        if (avm_read && avm_write) viol++;
        if (!reset && !busy && (avm_write || avm_read)) viol++;
        if (busy && (avm_address !== exp_addr || avm_burstcount !== exp_len)) stab_bad++;
        if (watch_ready && !cmd_ready) ready_bad++;
        if (err) err_cnt++;
        if (rd_valid) begin
            rd_cnt++;
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL rd_unexpected: rd_valid with rd_data 0x%0h, none expected", rd_data);
            end else begin
                check("rd_data", 32'(rd_data), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic issue(input logic rnw, input logic [AW-1:0] a, input logic [BW-1:0] l);
        int n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) check("cmd_ready_timeout", 32'(cmd_ready), 32'd1);
        exp_addr    = a;
        exp_len     = l;
        cmd_valid   = 1'b1;
        cmd_rnw     = rnw;
        cmd_address = a;
        cmd_length  = l;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic send_wdata(input logic [DW-1:0] base, input int n, input bit gaps);
        int idx = 0;
        int cyc = 0;
        while (idx < n && cyc < 5000) begin
            wr_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            wr_data  = base + DW'(idx);
            @(posedge clk);
            if (wr_valid && wr_ready) idx++;
            @(negedge clk);
            cyc++;
        end
        wr_valid = 1'b0;
        check("wr_beats_taken", 32'(idx), 32'(n));
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check({name, "_idle"}, 32'(busy), 32'd0);
        @(negedge clk);
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [BW-1:0] l,
                            input logic [DW-1:0] base, input bit gaps);
        int w0 = s_wr_total;
        issue(1'b0, a, l);
        send_wdata(base, int'(l), gaps);
        wait_idle("wr");
        check("wr_accepted", 32'(s_wr_total - w0), 32'(l));
        check("avm_write_low", 32'(avm_write), 32'd0);
    endtask

    task automatic do_read(input logic [AW-1:0] a, input logic [BW-1:0] l,
                           input logic [DW-1:0] base);
        int r0 = rd_cnt;
        for (int i = 0; i < int'(l); i++) exp_q.push_back(base + DW'(i));
        issue(1'b1, a, l);
        wait_idle("rd");
        check("rd_count", 32'(rd_cnt - r0), 32'(l));
        check("rd_q_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int e0;
        int r0;
        int n;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_avm_write", 32'(avm_write), 32'd0);
        check("rst_avm_read", 32'(avm_read), 32'd0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_avm_address", 32'(avm_address), 32'd0);
        check("rst_avm_burstcount", 32'(avm_burstcount), 32'd0);
        check("rst_avm_writedata", 32'(avm_writedata), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("cmd_ready_after_reset", 32'(cmd_ready), 32'd1);

        // 8-beat write then readback.
        do_write(8'h10, 8'd8, 16'h0100, 1'b0);
        do_read(8'h10, 8'd8, 16'h0100);
        check("busy_after_rd8", 32'(busy), 32'd0);

        // Single-beat burst at the top address.
        do_write(8'hFF, 8'd1, 16'hABCD, 1'b0);
        do_read(8'hFF, 8'd1, 16'hABCD);

        // Maximum-length burst with a gappy write stream.
        do_write(8'h80, 8'd128, 16'h1000, 1'b1);
        do_read(8'h80, 8'd128, 16'h1000);
        check("addr_len_stable", 32'(stab_bad), 32'd0);

        // Illegal lengths 0 and 129.
        e0 = err_cnt;
        watch_ready = 1'b1;
        issue(1'b0, 8'h20, 8'd0);
        check("err_pulse_len0", 32'(err), 32'd1);
        @(negedge clk);
        check("err_clear_len0", 32'(err), 32'd0);
        issue(1'b1, 8'h20, 8'd129);
        check("err_pulse_len129", 32'(err), 32'd1);
        repeat (3) @(negedge clk);
        watch_ready = 1'b0;
        check("err_count", 32'(err_cnt - e0), 32'd2);
        check("illegal_ready_held", 32'(ready_bad), 32'd0);
        check("illegal_busy", 32'(busy), 32'd0);

        // Reset after 3 of 8 read beats.
        for (int i = 0; i < 8; i++) exp_q.push_back(16'h0100 + DW'(i));
        r0 = rd_cnt;
        issue(1'b1, 8'h10, 8'd8);
        n = 0;
        while ((rd_cnt - r0) < 3 && n < 1000) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("rd_before_reset", 32'(rd_cnt - r0), 32'd3);
        reset = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_rd_valid", 32'(rd_valid), 32'd0);
        check("midrst_avm_read", 32'(avm_read), 32'd0);
        reset = 1'b0;
        n = 0;
        while (s_rleft > 0 && n < 1000) begin
            @(negedge clk);
            #1;
            n++;
        end
        repeat (3) @(negedge clk);
        check("rd_after_reset", 32'(rd_cnt - r0), 32'd3);
        check("midrst_ready", 32'(cmd_ready), 32'd1);
        do_write(8'h40, 8'd4, 16'h0300, 1'b0);
        do_read(8'h40, 8'd4, 16'h0300);

        check("no_rw_violation", 32'(viol), 32'd0);
        check("addr_len_stable_final", 32'(stab_bad), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit, %0d tests run", tests);
        $fatal(1);
    end

endmodule
